// File: rtl/regfile_write_arbiter.sv
// Two-requester round-robin write arbiter in front of a 32x32 register file.
// Optional read-after-write bypass outputs are compiled in with REGFILE_ARB_BYPASS_EN.
module regfile_write_arbiter #(
  parameter bit PRIO_INIT = 1'b0
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        ReqA_Valid,
  input  logic [4:0]  ReqA_Addr,
  input  logic [31:0] ReqA_Data,
  output logic        ReqA_Ready,
  input  logic        ReqB_Valid,
  input  logic [4:0]  ReqB_Addr,
  input  logic [31:0] ReqB_Data,
  output logic        ReqB_Ready,
  input  logic        Stall,
  output logic        RegWrite,
  output logic [4:0]  WriteRegister,
  output logic [31:0] WriteData,
  output logic [7:0]  DropCount
`ifdef REGFILE_ARB_BYPASS_EN
  ,
  input  logic [4:0]  ReadRegister1,
  input  logic [4:0]  ReadRegister2,
  output logic        Bypass1,
  output logic        Bypass2,
  output logic [31:0] BypassData
`endif
);

  // prio_q: 1'b0 = A holds priority, 1'b1 = B holds priority
  logic        prio_q, prio_d;
  logic        we_q, we_d;
  logic [4:0]  waddr_q, waddr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [7:0]  drop_q, drop_d;

  logic        ready_a_s, ready_b_s, grant_s;
  logic [4:0]  gaddr_s;
  logic [31:0] gdata_s;

  // Ready is gated by reset so nothing is accepted while Reset_n is low
  always_comb begin
    ready_a_s = 1'b0;
    ready_b_s = 1'b0;
    if (Reset_n && !Stall) begin
      ready_a_s = ReqA_Valid && (!ReqB_Valid || !prio_q);
      ready_b_s = ReqB_Valid && (!ReqA_Valid || prio_q);
    end else begin
      ready_a_s = 1'b0;
      ready_b_s = 1'b0;
    end
  end

  assign grant_s = ready_a_s || ready_b_s;

  // Granted request mux and next-state for priority, write port and drop counter
  always_comb begin
    gaddr_s = 5'd0;
    gdata_s = 32'd0;
    prio_d  = prio_q;
    we_d    = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    drop_d  = drop_q;

    if (ready_a_s) begin
      gaddr_s = ReqA_Addr;
      gdata_s = ReqA_Data;
      prio_d  = 1'b1;
    end else if (ready_b_s) begin
      gaddr_s = ReqB_Addr;
      gdata_s = ReqB_Data;
      prio_d  = 1'b0;
    end else begin
      gaddr_s = 5'd0;
      gdata_s = 32'd0;
      prio_d  = prio_q;
    end

    // Writes to register 0 are consumed but never reach the register file
    if (grant_s && (gaddr_s != 5'd0)) begin
      we_d    = 1'b1;
      waddr_d = gaddr_s;
      wdata_d = gdata_s;
    end else begin
      we_d    = 1'b0;
      waddr_d = waddr_q;
      wdata_d = wdata_q;
    end

    if (grant_s && (gaddr_s == 5'd0) && (drop_q != 8'd255)) begin
      drop_d = drop_q + 8'd1;
    end else begin
      drop_d = drop_q;
    end
  end

  // Registered write port state; reset drops any in-flight write at once
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      prio_q  <= PRIO_INIT;
      we_q    <= 1'b0;
      waddr_q <= 5'd0;
      wdata_q <= 32'd0;
      drop_q  <= 8'd0;
    end else begin
      prio_q  <= prio_d;
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      drop_q  <= drop_d;
    end
  end

  assign ReqA_Ready    = ready_a_s;
  assign ReqB_Ready    = ready_b_s;
  assign RegWrite      = we_q;
  assign WriteRegister = waddr_q;
  assign WriteData     = wdata_q;
  assign DropCount     = drop_q;

`ifdef REGFILE_ARB_BYPASS_EN
  // Forward the write being committed this cycle to matching readers
  always_comb begin
    Bypass1 = 1'b0;
    Bypass2 = 1'b0;
    if (we_q && (waddr_q != 5'd0)) begin
      Bypass1 = (ReadRegister1 == waddr_q);
      Bypass2 = (ReadRegister2 == waddr_q);
    end else begin
      Bypass1 = 1'b0;
      Bypass2 = 1'b0;
    end
  end

  assign BypassData = wdata_q;
`endif

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Self-checking bench for regfile_write_arbiter: directed scenarios plus randomized
// traffic compared against a grant-level reference model.
module tb_regfile_write_arbiter;

  localparam bit PRIO_INIT = 1'b0;

  logic        Clk = 1'b0;
  logic        Reset_n = 1'b0;
  logic        ReqA_Valid = 1'b0, ReqB_Valid = 1'b0, Stall = 1'b0;
  logic [4:0]  ReqA_Addr = 5'd0, ReqB_Addr = 5'd0;
  logic [31:0] ReqA_Data = 32'd0, ReqB_Data = 32'd0;
  logic        ReqA_Ready, ReqB_Ready, RegWrite;
  logic [4:0]  WriteRegister;
  logic [31:0] WriteData;
  logic [7:0]  DropCount;
`ifdef REGFILE_ARB_BYPASS_EN
  logic [4:0]  ReadRegister1 = 5'd0, ReadRegister2 = 5'd0;
  logic        Bypass1, Bypass2;
  logic [31:0] BypassData;
`endif

  int checks = 0;
  int errors = 0;

  regfile_write_arbiter #(.PRIO_INIT(PRIO_INIT)) dut (
    .Clk(Clk), .Reset_n(Reset_n),
    .ReqA_Valid(ReqA_Valid), .ReqA_Addr(ReqA_Addr), .ReqA_Data(ReqA_Data), .ReqA_Ready(ReqA_Ready),
    .ReqB_Valid(ReqB_Valid), .ReqB_Addr(ReqB_Addr), .ReqB_Data(ReqB_Data), .ReqB_Ready(ReqB_Ready),
    .Stall(Stall), .RegWrite(RegWrite), .WriteRegister(WriteRegister),
    .WriteData(WriteData), .DropCount(DropCount)
`ifdef REGFILE_ARB_BYPASS_EN
    , .ReadRegister1(ReadRegister1), .ReadRegister2(ReadRegister2),
    .Bypass1(Bypass1), .Bypass2(Bypass2), .BypassData(BypassData)
`endif
  );

  always #5 Clk = ~Clk;

  // Reference model: who wins this cycle (0 none, 1 A, 2 B), who was granted last,
  // total drops (unbounded) and the last real write presented to the register file.
  int          m_last;       // 0 = A granted last, 1 = B granted last
  int          m_drops;
  logic        m_we;
  logic [4:0]  m_addr;
  logic [31:0] m_data;
  int          m_win;
  logic [4:0]  m_gaddr;
  logic [31:0] m_gdata;
  logic [7:0]  m_dropsat;
  logic [45:0] m_out;

  function automatic int pick(input logic rst, input logic st, input logic va,
                              input logic vb, input int last);
    if (!rst || st) return 0;
    if (va && vb) return (last == 0) ? 2 : 1;
    if (va) return 1;
    if (vb) return 2;
    return 0;
  endfunction

  always_comb begin
    m_win   = pick(Reset_n, Stall, ReqA_Valid, ReqB_Valid, m_last);
    m_gaddr = (m_win == 1) ? ReqA_Addr : ReqB_Addr;
    m_gdata = (m_win == 1) ? ReqA_Data : ReqB_Data;
    m_dropsat = (m_drops > 255) ? 8'd255 : 8'(m_drops);
    m_out   = {m_we, m_addr, m_data, m_dropsat};
  end

  always @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      m_last  <= (PRIO_INIT == 1'b0) ? 1 : 0;
      m_drops <= 0;
      m_we    <= 1'b0;
      m_addr  <= 5'd0;
      m_data  <= 32'd0;
    end else if (m_win != 0) begin
      m_last <= (m_win == 1) ? 0 : 1;
      if (m_gaddr == 5'd0) begin
        m_we    <= 1'b0;
        m_drops <= m_drops + 1;
      end else begin
        m_we   <= 1'b1;
        m_addr <= m_gaddr;
        m_data <= m_gdata;
      end
    end else begin
      m_we <= 1'b0;
    end
  end

  task automatic drive(input logic va, input logic [4:0] aa, input logic [31:0] ad,
                       input logic vb, input logic [4:0] ba, input logic [31:0] bd,
                       input logic st);
    ReqA_Valid = va; ReqA_Addr = aa; ReqA_Data = ad;
    ReqB_Valid = vb; ReqB_Addr = ba; ReqB_Data = bd;
    Stall = st;
  endtask

  task automatic do_reset();
    @(negedge Clk);
    Reset_n = 1'b0;
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0);
    @(negedge Clk);
    Reset_n = 1'b1;
  endtask

  task automatic test_reset();
    Reset_n = 1'b0;
    drive(1'b1, 5'd5, 32'h1, 1'b1, 5'd6, 32'h2, 1'b0);
    repeat (2) @(negedge Clk);
    #1;
    checks++;
    if ({ReqA_Ready, ReqB_Ready} !== 2'b00) begin
      errors++; $display("FAIL reset_ready: got %b want 00", {ReqA_Ready, ReqB_Ready});
    end
    checks++;
    if ({RegWrite, WriteRegister, WriteData, DropCount} !== 46'd0) begin
      errors++; $display("FAIL reset_outputs: got we=%b addr=%0d data=%h drop=%0d want all zero",
                         RegWrite, WriteRegister, WriteData, DropCount);
    end
    Reset_n = 1'b1;
  endtask

  task automatic test_alternate();
    do_reset();
    drive(1'b1, 5'd5, 32'h11111111, 1'b1, 5'd6, 32'h22222222, 1'b0);
    #1;
    checks++;
    if ({ReqA_Ready, ReqB_Ready} !== 2'b10) begin
      errors++; $display("FAIL alt_grant1: got %b want 10", {ReqA_Ready, ReqB_Ready});
    end
    @(negedge Clk);
    checks++;
    if ({RegWrite, WriteRegister, WriteData} !== {1'b1, 5'd5, 32'h11111111}) begin
      errors++; $display("FAIL alt_write1: got we=%b addr=%0d data=%h want 1/5/11111111",
                         RegWrite, WriteRegister, WriteData);
    end
    #1;
    checks++;
    if ({ReqA_Ready, ReqB_Ready} !== 2'b01) begin
      errors++; $display("FAIL alt_grant2: got %b want 01", {ReqA_Ready, ReqB_Ready});
    end
    @(negedge Clk);
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0);
    checks++;
    if ({RegWrite, WriteRegister, WriteData} !== {1'b1, 5'd6, 32'h22222222}) begin
      errors++; $display("FAIL alt_write2: got we=%b addr=%0d data=%h want 1/6/22222222",
                         RegWrite, WriteRegister, WriteData);
    end
    @(negedge Clk);
    checks++;
    if ({RegWrite, WriteRegister, WriteData} !== {1'b0, 5'd6, 32'h22222222}) begin
      errors++; $display("FAIL alt_idle_hold: got we=%b addr=%0d data=%h want 0/6/22222222",
                         RegWrite, WriteRegister, WriteData);
    end
  endtask

  task automatic test_drop();
    do_reset();
    drive(1'b1, 5'd0, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (ReqA_Ready !== 1'b1) begin
        errors++; $display("FAIL drop_ready[%0d]: got %b want 1", i, ReqA_Ready);
      end
      @(negedge Clk);
      checks++;
      if ({RegWrite, DropCount} !== {1'b0, 8'(i + 1)}) begin
        errors++; $display("FAIL drop_count[%0d]: got we=%b drop=%0d want 0/%0d",
                           i, RegWrite, DropCount, i + 1);
      end
    end
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0);
  endtask

  task automatic test_stall();
    do_reset();
    drive(1'b1, 5'd3, 32'h3333, 1'b0, 5'd0, 32'd0, 1'b0);
    @(negedge Clk);
    drive(1'b1, 5'd4, 32'h4444, 1'b1, 5'd8, 32'h8888, 1'b1);
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++;
      if ({ReqA_Ready, ReqB_Ready} !== 2'b00) begin
        errors++; $display("FAIL stall_ready[%0d]: got %b want 00", i, {ReqA_Ready, ReqB_Ready});
      end
      @(negedge Clk);
      checks++;
      if (RegWrite !== 1'b0) begin
        errors++; $display("FAIL stall_we[%0d]: got %b want 0", i, RegWrite);
      end
    end
    Stall = 1'b0;
    #1;
    // A was granted before the stall, so B must still hold priority afterwards
    checks++;
    if ({ReqA_Ready, ReqB_Ready} !== 2'b01) begin
      errors++; $display("FAIL stall_resume: got %b want 01", {ReqA_Ready, ReqB_Ready});
    end
    @(negedge Clk);
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0);
  endtask

  task automatic test_reset_mid();
    do_reset();
    drive(1'b1, 5'd2, 32'h2222, 1'b0, 5'd0, 32'd0, 1'b0);
    @(negedge Clk);
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 32'h99999999, 1'b0);
    #1;
    checks++;
    if (ReqB_Ready !== 1'b1) begin
      errors++; $display("FAIL rstmid_pre_ready: got %b want 1", ReqB_Ready);
    end
    #2;
    Reset_n = 1'b0;
    #1;
    checks++;
    if (ReqB_Ready !== 1'b0) begin
      errors++; $display("FAIL rstmid_ready_low: got %b want 0", ReqB_Ready);
    end
    @(negedge Clk);
    checks++;
    if ({RegWrite, WriteRegister, WriteData, DropCount} !== 46'd0) begin
      errors++; $display("FAIL rstmid_outputs: got we=%b addr=%0d data=%h drop=%0d want all zero",
                         RegWrite, WriteRegister, WriteData, DropCount);
    end
    Reset_n = 1'b1;
    drive(1'b1, 5'd1, 32'h1, 1'b1, 5'd9, 32'h9, 1'b0);
    #1;
    checks++;
    if ({ReqA_Ready, ReqB_Ready} !== {~PRIO_INIT, PRIO_INIT}) begin
      errors++; $display("FAIL rstmid_prio: got %b want %b", {ReqA_Ready, ReqB_Ready},
                         {~PRIO_INIT, PRIO_INIT});
    end
    @(negedge Clk);
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0);
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 5'(i + 10), 32'(i) + 32'hA000, 1'b1, 5'(i + 20), 32'(i) + 32'hB000, 1'b0);
      #1;
      checks++;
      if ({ReqA_Ready, ReqB_Ready} !== ((i % 2 == 0) ? 2'b10 : 2'b01)) begin
        errors++; $display("FAIL b2b_ready[%0d]: got %b want %b", i, {ReqA_Ready, ReqB_Ready},
                           (i % 2 == 0) ? 2'b10 : 2'b01);
      end
      @(negedge Clk);
      checks++;
      if ({RegWrite, WriteRegister} !== {1'b1, 5'((i % 2 == 0) ? i + 10 : i + 20)}) begin
        errors++; $display("FAIL b2b_write[%0d]: got we=%b addr=%0d want 1/%0d", i, RegWrite,
                           WriteRegister, (i % 2 == 0) ? i + 10 : i + 20);
      end
    end
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0);
  endtask

  task automatic test_saturate();
    do_reset();
    for (int i = 0; i < 300; i++) begin
      drive(1'b1, 5'd0, $urandom(), 1'($urandom_range(1, 0)), 5'd0, $urandom(), 1'b0);
      @(negedge Clk);
      checks++;
      if ({RegWrite, WriteRegister, WriteData, DropCount} !== m_out) begin
        errors++; $display("FAIL sat_cycle[%0d]: got %h want %h",
                           i, {RegWrite, WriteRegister, WriteData, DropCount}, m_out);
      end
    end
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0);
    checks++;
    if (DropCount !== 8'd255) begin
      errors++; $display("FAIL sat_final: got %0d want 255", DropCount);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 500; i++) begin
      drive(1'($urandom_range(1, 0)),
            ($urandom_range(3, 0) == 0) ? 5'd0 : 5'($urandom_range(31, 0)), $urandom(),
            1'($urandom_range(1, 0)),
            ($urandom_range(3, 0) == 0) ? 5'd0 : 5'($urandom_range(31, 0)), $urandom(),
            ($urandom_range(3, 0) == 0));
      #1;
      checks++;
      if ({ReqA_Ready, ReqB_Ready} !== {m_win == 1, m_win == 2}) begin
        errors++; $display("FAIL rand_ready[%0d]: got %b want %b", i,
                           {ReqA_Ready, ReqB_Ready}, {m_win == 1, m_win == 2});
      end
      @(negedge Clk);
      checks++;
      if ({RegWrite, WriteRegister, WriteData, DropCount} !== m_out) begin
        errors++; $display("FAIL rand_out[%0d]: got %h want %h",
                           i, {RegWrite, WriteRegister, WriteData, DropCount}, m_out);
      end
    end
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0);
  endtask

`ifdef REGFILE_ARB_BYPASS_EN
  task automatic test_bypass();
    do_reset();
    ReadRegister1 = 5'd7;
    ReadRegister2 = 5'd8;
    drive(1'b1, 5'd7, 32'hCAFEF00D, 1'b0, 5'd0, 32'd0, 1'b0);
    @(negedge Clk);
    drive(1'b1, 5'd0, 32'h12345678, 1'b0, 5'd0, 32'd0, 1'b0);
    #1;
    checks++;
    if ({Bypass1, Bypass2, BypassData} !== {1'b1, 1'b0, 32'hCAFEF00D}) begin
      errors++; $display("FAIL bypass_hit: got b1=%b b2=%b data=%h want 1/0/cafef00d",
                         Bypass1, Bypass2, BypassData);
    end
    @(negedge Clk);
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0);
    ReadRegister1 = 5'd0;
    ReadRegister2 = 5'd7;
    #1;
    checks++;
    if ({Bypass1, Bypass2} !== 2'b00) begin
      errors++; $display("FAIL bypass_zero: got %b want 00", {Bypass1, Bypass2});
    end
  endtask
`endif

  initial begin
    test_reset();
    test_alternate();
    test_drop();
    test_stall();
    test_reset_mid();
    test_back_to_back();
    test_saturate();
    test_random();
`ifdef REGFILE_ARB_BYPASS_EN
    test_bypass();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/regfile_write_arbiter.md
REGFILE_WRITE_ARBITER -- requirements
Module: regfile_write_arbiter

Interface
REQ-001 Parameter: PRIO_INIT, default 0, requester holding priority after reset (0 = A, 1 = B).
REQ-002 Clk  input  1  clock; all state updates on the positive edge.
REQ-003 Reset_n  input  1  reset; asynchronous, active-low.
REQ-004 ReqA_Valid  input  1  requester A has a write pending.
REQ-005 ReqA_Addr  input  5  requester A destination register.
REQ-006 ReqA_Data  input  32  requester A write data.
REQ-007 ReqA_Ready  output  1  requester A accepted this cycle.
REQ-008 ReqB_Valid / ReqB_Addr / ReqB_Data / ReqB_Ready  same widths and meanings as the A signals, for requester B.
REQ-009 Stall  input  1  when high, no request is granted.
REQ-010 RegWrite  output  1  write enable to the register file.
REQ-011 WriteRegister  output  5  write address to the register file.
REQ-012 WriteData  output  32  write data to the register file.
REQ-013 DropCount  output  8  count of accepted writes targeting register 0.

Function
REQ-014 The block SHALL grant at most one requester per cycle; a grant occurs on a cycle when Ready and Valid are both high.
REQ-015 ReqX_Ready SHALL be combinational: high only when Stall=0, ReqX_Valid=1, and either the other requester is not valid or X holds priority.
REQ-016 Round-robin: after any grant, priority SHALL pass to the non-granted requester; with no grant, priority SHALL hold.
REQ-017 A granted request SHALL be registered and presented on WriteRegister/WriteData with RegWrite=1 for exactly the one following cycle (latency 1).
REQ-018 Any cycle without a grant SHALL be followed by RegWrite=0; WriteRegister/WriteData SHALL hold their last values.
REQ-019 A granted request with Addr=0 SHALL be accepted (Ready=1) but SHALL produce RegWrite=0 the next cycle, and SHALL increment DropCount.
REQ-020 DropCount SHALL saturate at 255 and not wrap.
REQ-021 A requester with Valid held high and no grant SHALL NOT have its request dropped; the request remains the requester's responsibility until Ready.
REQ-022 With both requesters valid continuously and Stall=0, grants SHALL alternate A,B,A,B (or B,A,... per priority); neither waits more than one cycle.
REQ-023 Stall asserted SHALL force both Ready low in the same cycle, and SHALL leave the priority unchanged.
REQ-024 Back-to-back grants SHALL produce back-to-back RegWrite pulses with no bubble.

Reset
REQ-025 While Reset_n=0: RegWrite=0, WriteRegister=0, WriteData=0, DropCount=0, priority=PRIO_INIT, and bypass state (if compiled) cleared.
REQ-026 Reset asserted mid-operation SHALL discard the registered write immediately; no RegWrite pulse occurs for a request granted in the cycle reset asserts.
REQ-027 Ready outputs SHALL be low while Reset_n=0.

Configuration
REQ-028 Macro REGFILE_ARB_BYPASS_EN: when defined, the block SHALL add ports ReadRegister1 (input 5), ReadRegister2 (input 5), Bypass1 (output 1), Bypass2 (output 1), BypassData (output 32).
REQ-029 With REGFILE_ARB_BYPASS_EN defined: BypassN SHALL be high combinationally when RegWrite=1 and ReadRegisterN equals WriteRegister (nonzero), and BypassData SHALL equal WriteData.
REQ-030 Without REGFILE_ARB_BYPASS_EN: those ports and their logic SHALL NOT exist; all other behaviour is identical.

Verification
REQ-031 Reset with PRIO_INIT=0, A and B both valid (A: addr 5, data 0x11111111; B: addr 6, data 0x22222222) for 2 cycles -> A granted in cycle 1, B in cycle 2; RegWrite=1 with addr 5 then 6 in cycles 2 and 3.
REQ-032 A alone valid, addr 0, data 0xDEADBEEF, 3 cycles -> ReqA_Ready=1 every cycle, RegWrite stays 0, DropCount=3.
REQ-033 Both valid with Stall=1 for 4 cycles, then Stall=0 -> no Ready during stall; the first grant after stall goes to the priority holder from before the stall.
REQ-034 B granted (addr 9), Reset_n driven low in the same cycle -> RegWrite=0 next cycle, outputs zero, priority=PRIO_INIT.
REQ-035 300 grants to register 0 -> DropCount=255.
REQ-036 With bypass compiled: grant A addr 7, data 0xCAFEF00D, ReadRegister1=7, ReadRegister2=8 -> next cycle Bypass1=1, Bypass2=0, BypassData=0xCAFEF00D; addr 0 write -> both Bypass low.
